// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional parity and error pulses
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
// Ports:
//   CLK        rising-edge receiver clock
//   RST        asynchronous active-low reset
//   RX_IN      serial line, idle high, asynchronous to CLK
//   PRESCALE   CLK cycles per bit (8, 16 or 32), latched at frame start
//   PAR_EN     frame carries a parity bit, latched at frame start
//   PAR_TYP    0 even / 1 odd parity, latched at frame start
//   P_DATA     last good received word
//   DATA_VALID one-cycle pulse when P_DATA is updated
//   PAR_ERR    one-cycle pulse on parity mismatch
//   STP_ERR    one-cycle pulse on a low stop bit
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int BW = $clog2(DATA_WIDTH + 1);
  state_t                state;
  logic                  s1, line;
  logic [5:0]            cnt, pre, mid;
  logic [BW-1:0]         bcnt;
  logic                  par_en_q, par_typ_q, par_bad;
  logic [DATA_WIDTH-1:0] sreg;
  logic                  samp_pt, bit_v, bit_end;
  assign mid = {1'b0, pre[5:1]};
  assign bit_end = cnt == pre - 6'd1;
  // The edge counter names the value cnt takes at an edge, so the sample
  // "at count X" happens on the edge where cnt moves from X-1 to X.
`ifdef UART_RX_MAJORITY_EN
  logic m0, m1;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) {m0, m1} <= 2'b11;
    else begin
      if (cnt == mid - 6'd2) m0 <= line;
      if (cnt == mid - 6'd1) m1 <= line;
    end
  assign samp_pt = cnt == mid;
  assign bit_v = (m0 & m1) | (m0 & line) | (m1 & line);
`else
  assign samp_pt = cnt == mid - 6'd1;
  assign bit_v = line;
`endif
  always_ff @(posedge CLK or negedge RST)
    if (!RST) {s1, line} <= 2'b11;
    else {s1, line} <= {RX_IN, s1};
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      bcnt       <= '0;
      pre        <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad    <= 1'b0;
      sreg       <= '0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      cnt        <= (state == IDLE || bit_end) ? 6'd0 : cnt + 6'd1;
      case (state)
        IDLE:
          if (!line) begin
            state     <= START;
            pre       <= PRESCALE;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            bcnt      <= '0;
            par_bad   <= 1'b0;
          end
        START:
          if (samp_pt && bit_v) state <= IDLE;
          else if (bit_end) state <= DATA;
        DATA: begin
          if (samp_pt) begin
            sreg <= {bit_v, sreg[DATA_WIDTH-1:1]};
            bcnt <= BW'(bcnt + 1);
          end
          if (bit_end && bcnt == BW'(DATA_WIDTH)) state <= par_en_q ? PARITY : STOP;
        end
        PARITY: begin
          if (samp_pt) par_bad <= bit_v != (^sreg ^ par_typ_q);
          if (bit_end) state <= STOP;
        end
        STOP:
          // Leaving at the sample point, not the bit end, lets a start bit
          // that follows the stop bit directly be seen in IDLE.
          if (samp_pt) begin
            state   <= IDLE;
            STP_ERR <= !bit_v;
            PAR_ERR <= par_bad;
            if (bit_v && !par_bad) begin
              P_DATA     <= sreg;
              DATA_VALID <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_n = 0, pe_n = 0, se_n = 0;
  int dv_t = 0, pe_t = 0, se_t = 0;
  logic [7:0] ref_data;
  uart_rx dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (DATA_VALID) begin dv_n = dv_n + 1; dv_t = cyc; end
    if (PAR_ERR) begin pe_n = pe_n + 1; pe_t = cyc; end
    if (STP_ERR) begin se_n = se_n + 1; se_t = cyc; end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Drives one whole frame starting at a negedge and checks the outcome the
  // frame rules predict: a good frame yields exactly one DATA_VALID at
  // T0 + (1+8+pe)*p + p/2 (+1 with majority), T0 being three edges after the
  // start bit is driven (two synchronizer flops plus the IDLE decision edge).
  task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit pt,
                            input bit bad_par, input bit bad_stop);
    int k, t_exp, dv0, pe0, se0;
    bit par_fail, ok;
    k = cyc;
    t_exp = k + 3 + (9 + int'(pe)) * p + p / 2 + MAJ;
    dv0 = dv_n; pe0 = pe_n; se0 = se_n;
    PRESCALE = 6'(p); PAR_EN = pe; PAR_TYP = pt;
    RX_IN = 1'b0;
    repeat (4) @(negedge CLK);
    PRESCALE = 6'(p == 16 ? 32 : 16); PAR_EN = ~pe; PAR_TYP = ~pt;
    repeat (p - 4) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (p) @(negedge CLK);
    end
    if (pe) begin
      RX_IN = ^d ^ pt ^ bad_par;
      repeat (p) @(negedge CLK);
    end
    if (bad_stop) begin
      RX_IN = 1'b0;
      repeat (p / 2 + 1) @(negedge CLK);
      RX_IN = 1'b1;
      repeat (p - p / 2 - 1) @(negedge CLK);
    end else begin
      RX_IN = 1'b1;
      repeat (p) @(negedge CLK);
    end
    par_fail = pe && bad_par;
    ok = !bad_stop && !par_fail;
    if (ok) ref_data = d;
    chk("dv_count", dv_n - dv0, ok);
    if (ok) chk("dv_time", dv_t, t_exp);
    chk("par_err_count", pe_n - pe0, par_fail);
    if (par_fail) chk("par_err_time", pe_t, t_exp);
    chk("stp_err_count", se_n - se0, bad_stop);
    if (bad_stop) chk("stp_err_time", se_t, t_exp);
    chk("p_data", P_DATA, ref_data);
  endtask
  initial begin
    int p, t1, dv0, pe0, se0;
    logic [7:0] d;
    bit pe, pt, bp, bs;
    RST = 1'b0; RX_IN = 1'b1; PRESCALE = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    ref_data = 8'h00;
    repeat (3) @(negedge CLK);
    chk("rst_p_data", P_DATA, 8'h00);
    chk("rst_dv", DATA_VALID, 1'b0);
    chk("rst_par_err", PAR_ERR, 1'b0);
    chk("rst_stp_err", STP_ERR, 1'b0);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b1);
    PRESCALE = 6'd16; PAR_EN = 1'b0;
    dv0 = dv_n; pe0 = pe_n; se0 = se_n;
    RX_IN = 1'b0;
    repeat (4) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (48) @(negedge CLK);
    chk("glitch_dv", dv_n - dv0, 0);
    chk("glitch_par_err", pe_n - pe0, 0);
    chk("glitch_stp_err", se_n - se0, 0);
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge CLK);
    send_frame(8'h01, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    t1 = dv_t;
    send_frame(8'hFE, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_gap", dv_t - t1, 160);
    d = 8'h77;
    PRESCALE = 6'd16; PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (16) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      RX_IN = d[i];
      repeat (16) @(negedge CLK);
    end
    RST = 1'b0;
    #1;
    chk("midrst_p_data", P_DATA, 8'h00);
    chk("midrst_dv", DATA_VALID, 1'b0);
    chk("midrst_par_err", PAR_ERR, 1'b0);
    chk("midrst_stp_err", STP_ERR, 1'b0);
    ref_data = 8'h00;
    dv0 = dv_n; pe0 = pe_n; se0 = se_n;
    repeat (3) @(negedge CLK);
    RST = 1'b1; RX_IN = 1'b1;
    repeat (40) @(negedge CLK);
    chk("postrst_pulses", (dv_n - dv0) + (pe_n - pe0) + (se_n - se0), 0);
    send_frame(8'h12, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      p = 8 << $urandom_range(0, 2);
      d = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      bp = $urandom_range(0, 3) == 0;
      bs = $urandom_range(0, 5) == 0;
      send_frame(d, p, pe, pt, bp, bs);
      repeat ($urandom_range(0, 5)) @(negedge CLK);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
